// File: rtl/cory_demux4_pkg.sv
// Shared constants and helpers for the cory stream demultiplexer.
// Holds the way count, select width and statistics counter width.
package cory_pkg;

    localparam int CORY_DEMUX_WAYS = 4;
    localparam int CORY_SEL_W      = 2;
    localparam int CORY_STAT_W     = 16;

    typedef logic [CORY_SEL_W-1:0] cory_sel_t;

    function automatic logic [CORY_DEMUX_WAYS-1:0] cory_onehot(
        input cory_sel_t s
    );
        return CORY_DEMUX_WAYS'(1) << s;
    endfunction

endpackage

// File: rtl/cory_demux4_if.sv
// Stream bundle of cory_demux4: joined data/select input, four outputs.
// slave is the demux view, master is the producer/consumer view.
interface cory_demux4_if #(
    parameter int N = 8
);
    import cory_pkg::*;

    logic            i_a_v;
    logic [N-1:0]    i_a_d;
    logic            o_a_r;
    logic            i_s_v;
    cory_sel_t       i_s_d;
    logic            o_s_r;
    logic            o_z0_v, o_z1_v, o_z2_v, o_z3_v;
    logic [N-1:0]    o_z0_d, o_z1_d, o_z2_d, o_z3_d;
    logic            i_z0_r, i_z1_r, i_z2_r, i_z3_r;

    modport slave (
        input  i_a_v, i_a_d, i_s_v, i_s_d,
        input  i_z0_r, i_z1_r, i_z2_r, i_z3_r,
        output o_a_r, o_s_r,
        output o_z0_v, o_z1_v, o_z2_v, o_z3_v,
        output o_z0_d, o_z1_d, o_z2_d, o_z3_d
    );

    modport master (
        output i_a_v, i_a_d, i_s_v, i_s_d,
        output i_z0_r, i_z1_r, i_z2_r, i_z3_r,
        input  o_a_r, o_s_r,
        input  o_z0_v, o_z1_v, o_z2_v, o_z3_v,
        input  o_z0_d, o_z1_d, o_z2_d, o_z3_d
    );

endinterface

// File: rtl/cory_demux4_queue.sv
// cory_queue: Q-deep per-destination FIFO; Q=0 is a wire, Q=1 a flagged register.
// wr_ok_o depends only on registered state (Q>0), so it never loops to req_i.
module cory_queue #(
    parameter int N = 8,
    parameter int Q = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_i,
    input  logic [N-1:0] data_i,
    output logic         wr_ok_o,
    output logic         valid_o,
    output logic [N-1:0] data_o,
    input  logic         rdy_i
);

    generate
        if (Q == 0) begin : g_pass
            assign wr_ok_o = rdy_i;
            assign valid_o = req_i;
            assign data_o  = data_i;
        end else if (Q == 1) begin : g_one
            logic [N-1:0] data_q;
            logic         full_q, full_d;
            logic         push, pop;

            assign wr_ok_o = !full_q;
            assign push    = req_i & !full_q;
            assign pop     = full_q & rdy_i;
            assign valid_o = full_q;
            assign data_o  = data_q;

            // Full flag: set on push, cleared on pop (never both at once).
            always_comb begin
                full_d = full_q;
                if (push) full_d = 1'b1;
                else if (pop) full_d = 1'b0;
            end

            // Single storage register plus its occupancy flag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    full_q <= 1'b0;
                end else begin
                    full_q <= full_d;
                    if (push) data_q <= data_i;
                end
            end
        end else begin : g_ring
            localparam int PW = $clog2(Q);
            localparam int CW = $clog2(Q + 1);

            logic [N-1:0]  mem_q [Q];
            logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          push, pop;

            assign wr_ok_o = cnt_q < CW'(Q);
            assign valid_o = cnt_q != '0;
            assign data_o  = mem_q[rp_q];
            assign push    = req_i & wr_ok_o;
            assign pop     = valid_o & rdy_i;

            // Pointer wrap at Q-1 so non-power-of-two depths work.
            always_comb begin
                wp_d  = wp_q;
                rp_d  = rp_q;
                cnt_d = cnt_q;
                if (push) wp_d = (wp_q == PW'(Q - 1)) ? '0 : wp_q + 1'b1;
                if (pop)  rp_d = (rp_q == PW'(Q - 1)) ? '0 : rp_q + 1'b1;
                unique case ({push, pop})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end

            // Ring storage, pointers and occupancy count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < Q; i++) mem_q[i] <= '0;
                    wp_q  <= '0;
                    rp_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push) mem_q[wp_q] <= data_i;
                    wp_q  <= wp_d;
                    rp_q  <= rp_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cory_demux4.sv
// cory_demux4: joins data and select streams and steers each beat to one of four FIFOs.
// Optional per-destination beat counters on o_stat_d when CORY_DEMUX4_STAT_EN is defined.
module cory_demux4
    import cory_pkg::*;
#(
    parameter int N = 8,
    parameter int Q = 2
) (
    input  logic clk,
    input  logic reset_n,
    cory_demux4_if.slave bus
`ifdef CORY_DEMUX4_STAT_EN
    ,
    output logic [CORY_DEMUX_WAYS*CORY_STAT_W-1:0] o_stat_d
`endif
);

    localparam int W = CORY_DEMUX_WAYS;

    logic [W-1:0] req, rdy, ok, vld;
    logic [N-1:0] zd [W];
    logic         join_v, sel_ok;

    assign rdy    = {bus.i_z3_r, bus.i_z2_r, bus.i_z1_r, bus.i_z0_r};
    assign join_v = bus.i_a_v & bus.i_s_v & reset_n;
    assign sel_ok = ok[bus.i_s_d] & reset_n;
    assign req    = join_v ? cory_onehot(bus.i_s_d) : '0;

    assign bus.o_a_r = bus.i_s_v & sel_ok;
    assign bus.o_s_r = bus.i_a_v & sel_ok;

    generate
        for (genvar k = 0; k < W; k++) begin : g_way
            cory_queue #(
                .N(N),
                .Q(Q)
            ) u_q (
                .clk    (clk),
                .rst_n  (reset_n),
                .req_i  (req[k]),
                .data_i (bus.i_a_d),
                .wr_ok_o(ok[k]),
                .valid_o(vld[k]),
                .data_o (zd[k]),
                .rdy_i  (rdy[k])
            );
        end
    endgenerate

    assign bus.o_z0_v = vld[0];
    assign bus.o_z1_v = vld[1];
    assign bus.o_z2_v = vld[2];
    assign bus.o_z3_v = vld[3];
    assign bus.o_z0_d = zd[0];
    assign bus.o_z1_d = zd[1];
    assign bus.o_z2_d = zd[2];
    assign bus.o_z3_d = zd[3];

`ifdef CORY_DEMUX4_STAT_EN
    logic [CORY_STAT_W-1:0] stat_q [W];
    logic [CORY_STAT_W-1:0] stat_d [W];
    logic [W-1:0]           xfer;

    assign xfer = req & ok;

    // Count accepted beats per destination, wrapping naturally.
    always_comb begin
        for (int k = 0; k < W; k++) begin
            stat_d[k] = stat_q[k] + CORY_STAT_W'(xfer[k]);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < W; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < W; k++) stat_q[k] <= stat_d[k];
        end
    end

    generate
        for (genvar k = 0; k < W; k++) begin : g_stat
            assign o_stat_d[k*CORY_STAT_W +: CORY_STAT_W] = stat_q[k];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_cory_demux4.sv
// Bench for cory_demux4: directed vector table, corner sequences, random traffic.
// Reference model keeps one queue per destination plus beat counters.
module tb_cory_demux4;
    import cory_pkg::*;

    localparam int N  = 8;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cory_demux4_if #(.N(N)) bus ();
`ifdef CORY_DEMUX4_STAT_EN
    logic [63:0] stat;
`endif

    cory_demux4 #(
        .N(N),
        .Q(QD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef CORY_DEMUX4_STAT_EN
        ,
        .o_stat_d(stat)
`endif
    );

    logic [N-1:0] mq [4][$];
    logic [15:0]  mstat [4];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       av;
        logic       sv;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       ar;
        logic       sr;
        logic [3:0] v;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] get_v();
        return {bus.o_z3_v, bus.o_z2_v, bus.o_z1_v, bus.o_z0_v};
    endfunction

    function automatic logic [N-1:0] get_d(input int k);
        case (k)
            0: return bus.o_z0_d;
            1: return bus.o_z1_d;
            2: return bus.o_z2_d;
            default: return bus.o_z3_d;
        endcase
    endfunction

    function automatic logic [3:0] get_r();
        return {bus.i_z3_r, bus.i_z2_r, bus.i_z1_r, bus.i_z0_r};
    endfunction

    task automatic drive(input logic av, input logic sv, input logic [1:0] sel,
                         input logic [7:0] d, input logic [3:0] rdy);
        bus.i_a_v  = av;
        bus.i_s_v  = sv;
        bus.i_s_d  = sel;
        bus.i_a_d  = d;
        bus.i_z0_r = rdy[0];
        bus.i_z1_r = rdy[1];
        bus.i_z2_r = rdy[2];
        bus.i_z3_r = rdy[3];
    endtask

    task automatic check_model();
        logic full;
        logic [3:0] v;
        full = mq[int'(bus.i_s_d)].size() >= QD;
        chk("a_r", 64'(bus.o_a_r), 64'(bus.i_s_v & !full));
        chk("s_r", 64'(bus.o_s_r), 64'(bus.i_a_v & !full));
        v = get_v();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("z%0d_v", k), 64'(v[k]), 64'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                chk($sformatf("z%0d_d", k), 64'(get_d(k)), 64'(mq[k][0]));
        end
`ifdef CORY_DEMUX4_STAT_EN
        chk("stat", stat, {mstat[3], mstat[2], mstat[1], mstat[0]});
`endif
    endtask

    task automatic tick();
        logic x;
        logic [3:0] pop, r;
        int sel;
        logic [7:0] d;
        sel = int'(bus.i_s_d);
        d   = bus.i_a_d;
        r   = get_r();
        x   = bus.i_a_v & bus.i_s_v & (mq[sel].size() < QD);
        for (int k = 0; k < 4; k++) pop[k] = (mq[k].size() != 0) && r[k];
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pop[k]) void'(mq[k].pop_front());
        if (x) begin
            mq[sel].push_back(d);
            mstat[sel]++;
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic av, input logic sv, input logic [1:0] sel,
                         input logic [7:0] d, input logic [3:0] rdy);
        drive(av, sv, sel, d, rdy);
        #1;
        check_model();
        tick();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) mstat[k] = '0;
        tbl[0]  = '{1, 1, 0, 8'h11, 4'hF, 1, 1, 4'b0000};
        tbl[1]  = '{1, 1, 1, 8'h22, 4'hF, 1, 1, 4'b0001};
        tbl[2]  = '{1, 1, 2, 8'h33, 4'hF, 1, 1, 4'b0010};
        tbl[3]  = '{1, 1, 3, 8'h44, 4'hF, 1, 1, 4'b0100};
        tbl[4]  = '{0, 0, 0, 8'h00, 4'hF, 0, 0, 4'b1000};
        tbl[5]  = '{0, 0, 0, 8'h00, 4'hF, 0, 0, 4'b0000};
        tbl[6]  = '{1, 1, 1, 8'hA1, 4'hD, 1, 1, 4'b0000};
        tbl[7]  = '{1, 1, 1, 8'hA2, 4'hD, 1, 1, 4'b0010};
        tbl[8]  = '{1, 1, 1, 8'hA3, 4'hD, 0, 0, 4'b0010};
        tbl[9]  = '{1, 1, 1, 8'hA3, 4'hF, 0, 0, 4'b0010};
        tbl[10] = '{1, 1, 1, 8'hA3, 4'hF, 1, 1, 4'b0010};
        tbl[11] = '{0, 0, 0, 8'h00, 4'hF, 0, 0, 4'b0010};
        tbl[12] = '{0, 0, 0, 8'h00, 4'hF, 0, 0, 4'b0000};

        // reset state, with valids high to see readies held low
        drive(1, 1, 0, 8'h5A, 4'hF);
        #2;
        chk("rst_a_r", 64'(bus.o_a_r), 64'(0));
        chk("rst_s_r", 64'(bus.o_s_r), 64'(0));
        chk("rst_v", 64'(get_v()), 64'(0));
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst_z%0d_d", k), 64'(get_d(k)), 64'(0));
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 4'hF);
        reset_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].av, tbl[i].sv, tbl[i].sel, tbl[i].d, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_a_r", i), 64'(bus.o_a_r), 64'(tbl[i].ar));
            chk($sformatf("tbl%0d_s_r", i), 64'(bus.o_s_r), 64'(tbl[i].sr));
            chk($sformatf("tbl%0d_v", i), 64'(get_v()), 64'(tbl[i].v));
            check_model();
            tick();
        end

        // dest 2 full and stalled, dest 3 still flows
        cycle(1, 1, 2, 8'hC1, 4'hB);
        cycle(1, 1, 2, 8'hC2, 4'hB);
        drive(1, 1, 3, 8'h5C, 4'hB);
        #1;
        chk("other_dest_a_r", 64'(bus.o_a_r), 64'(1));
        check_model();
        tick();
        drive(0, 0, 0, 8'h00, 4'hB);
        #1;
        chk("z3_5c_v", 64'(bus.o_z3_v), 64'(1));
        chk("z3_5c_d", 64'(bus.o_z3_d), 64'(8'h5C));
        chk("z2_head", 64'(bus.o_z2_d), 64'(8'hC1));
        check_model();
        tick();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 4'hF);

        // data valid without select: nothing transfers
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 8'h77, 4'hF);
            #1;
            chk("unjoined_a_r", 64'(bus.o_a_r), 64'(0));
            chk("unjoined_v", 64'(get_v()), 64'(0));
            check_model();
            tick();
        end
        drive(1, 1, 1, 8'h77, 4'hF);
        #1;
        chk("joined_a_r", 64'(bus.o_a_r), 64'(1));
        check_model();
        tick();
        cycle(0, 0, 0, 8'h00, 4'hF);
        cycle(0, 0, 0, 8'h00, 4'hF);

        // dest 0 full: pop and new beat in same cycle, beat waits one cycle
        cycle(1, 1, 0, 8'hB1, 4'hE);
        cycle(1, 1, 0, 8'hB2, 4'hE);
        drive(1, 1, 0, 8'hB3, 4'hF);
        #1;
        chk("full_pop_a_r", 64'(bus.o_a_r), 64'(0));
        check_model();
        tick();
        drive(1, 1, 0, 8'hB3, 4'hF);
        #1;
        chk("after_pop_a_r", 64'(bus.o_a_r), 64'(1));
        check_model();
        tick();
        chk("q0_bound", 64'(mq[0].size() <= QD), 64'(1));
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 4'hF);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  2'($urandom), 8'($urandom), 4'($urandom));
        end

        // reset mid-stream with two beats buffered
        cycle(1, 1, 0, 8'hD1, 4'h0);
        cycle(1, 1, 1, 8'hD2, 4'h0);
        drive(1, 1, 2, 8'hD3, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_v", 64'(get_v()), 64'(0));
        chk("midrst_a_r", 64'(bus.o_a_r), 64'(0));
        chk("midrst_s_r", 64'(bus.o_s_r), 64'(0));
`ifdef CORY_DEMUX4_STAT_EN
        chk("midrst_stat", stat, 64'(0));
`endif
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mstat[k] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 4'hF);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 8'h00, 4'hF);
            #1;
            chk("postrst_v", 64'(get_v()), 64'(0));
            check_model();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
